// File: rtl/memarb_pkg.sv
// Shared types and constants for the SSRAM sequencer/arbiter.
package memarb_pkg;

  typedef enum logic [2:0] {IDLE, H0, H1, H2, ACK} memarb_state_t;

  typedef enum logic {OWN_CPU, OWN_CON} memarb_owner_t;

  // Half-select: bits [0:17] go out first, then bits [18:35].
  localparam logic HALF_HI = 1'b0;
  localparam logic HALF_LO = 1'b1;

  localparam int unsigned SSRAM_DW = 18;

endpackage

// File: rtl/memarb_sel.sv
// Grant selection: CPU priority with a bounded burst so the console cannot starve.
module memarb_sel
  import memarb_pkg::*;
#(
  parameter int unsigned CPU_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpuREQ,
  input  logic          conREQ,
  input  logic          idle,
  output logic          grantValid,
  output memarb_owner_t grantOwner
);

  localparam logic [3:0] BurstMax = 4'(CPU_BURST_MAX);

  logic [3:0] fairQ, fairD;

  // Combinational grant from the current requests and the burst counter.
  always_comb begin
    grantValid = cpuREQ | conREQ;
    grantOwner = OWN_CPU;
    if (conREQ && (!cpuREQ || fairQ == BurstMax)) begin
      grantOwner = OWN_CON;
    end
  end

  // Burst counter: counts CPU grants made while the console waits.
  always_comb begin
    fairD = fairQ;
    if (idle) begin
      if (!conREQ || grantOwner == OWN_CON) begin
        fairD = '0;
      end else if (cpuREQ && fairQ != BurstMax) begin
        fairD = fairQ + 4'd1;
      end
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fairQ <= '0;
    end else begin
      fairQ <= fairD;
    end
  end

endmodule

// File: rtl/ssram_arb.sv
// Two-word-burst SSRAM sequencer shared by the CPU and console ports.
// Optional grant/wait statistics are built when MEMARB_STATS_EN is defined.
module ssram_arb
  import memarb_pkg::*;
#(
  parameter int unsigned AW            = 20,
  parameter int unsigned CPU_BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpuREQ,
  input  logic                cpuWR,
  input  logic [AW-1:0]       cpuADDR,
  input  logic [35:0]         cpuDATAI,
  output logic                cpuACK,
  output logic [35:0]         cpuDATAO,
  input  logic                conREQ,
  input  logic                conWR,
  input  logic [AW-1:0]       conADDR,
  input  logic [35:0]         conDATAI,
  output logic                conACK,
  output logic [35:0]         conDATAO,
  output logic                busy,
  output logic [AW+1:0]       ssramA,
  output logic                ssramWE_N,
  output logic                ssramADV,
  output logic [SSRAM_DW-1:0] ssramDO,
  output logic                ssramOE,
  input  logic [SSRAM_DW-1:0] ssramDI,
  output logic [31:0]         statCPU,
  output logic [31:0]         statCON,
  output logic [31:0]         statWAIT
);

  memarb_state_t      stateQ, stateD;
  memarb_owner_t      ownerQ, grantOwner;
  logic               grantValid;
  logic               idleStb;
  logic               wrQ;
  logic [AW-1:0]      addrQ;
  logic [35:0]        dataQ;
  logic [SSRAM_DW-1:0] rdHiQ;
  logic [35:0]        cpuDataQ, conDataQ;

  assign idleStb  = (stateQ == IDLE);
  assign ssramADV = 1'b0;
  assign busy     = !idleStb;
  assign cpuDATAO = cpuDataQ;
  assign conDATAO = conDataQ;

  memarb_sel #(
    .CPU_BURST_MAX(CPU_BURST_MAX)
  ) u_sel (
    .clk        (clk),
    .rst        (rst),
    .cpuREQ     (cpuREQ),
    .conREQ     (conREQ),
    .idle       (idleStb),
    .grantValid (grantValid),
    .grantOwner (grantOwner)
  );

  // Next-state: fixed five-cycle walk once a grant is made.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (grantValid) stateD = H0;
      H0:      stateD = H1;
      H1:      stateD = H2;
      H2:      stateD = ACK;
      ACK:     stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Pad and handshake outputs decoded from the current state.
  always_comb begin
    ssramA    = '0;
    ssramWE_N = 1'b1;
    ssramOE   = 1'b0;
    ssramDO   = '0;
    cpuACK    = 1'b0;
    conACK    = 1'b0;
    case (stateQ)
      H0: begin
        ssramA = {1'b0, addrQ, HALF_HI};
        if (wrQ) begin
          ssramWE_N = 1'b0;
          ssramOE   = 1'b1;
          ssramDO   = dataQ[35:18];
        end
      end
      H1: begin
        ssramA = {1'b0, addrQ, HALF_LO};
        if (wrQ) begin
          ssramWE_N = 1'b0;
          ssramOE   = 1'b1;
          ssramDO   = dataQ[17:0];
        end
      end
      ACK: begin
        cpuACK = (ownerQ == OWN_CPU);
        conACK = (ownerQ == OWN_CON);
      end
      default: ;
    endcase
  end

  // State, request latch and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= IDLE;
      ownerQ   <= OWN_CPU;
      wrQ      <= 1'b0;
      addrQ    <= '0;
      dataQ    <= '0;
      rdHiQ    <= '0;
      cpuDataQ <= '0;
      conDataQ <= '0;
    end else begin
      stateQ <= stateD;
      if (idleStb && grantValid) begin
        ownerQ <= grantOwner;
        wrQ    <= (grantOwner == OWN_CPU) ? cpuWR    : conWR;
        addrQ  <= (grantOwner == OWN_CPU) ? cpuADDR  : conADDR;
        dataQ  <= (grantOwner == OWN_CPU) ? cpuDATAI : conDATAI;
      end
      if (stateQ == H1 && !wrQ) begin
        rdHiQ <= ssramDI;
      end
      // Second half lands straight in the owner's output so it is valid during ACK.
      if (stateQ == H2 && !wrQ) begin
        if (ownerQ == OWN_CPU) cpuDataQ <= {rdHiQ, ssramDI};
        else                   conDataQ <= {rdHiQ, ssramDI};
      end
    end
  end

`ifdef MEMARB_STATS_EN
  logic [31:0] statCpuQ, statConQ, statWaitQ;

  // Saturating grant and console-wait counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statCpuQ  <= '0;
      statConQ  <= '0;
      statWaitQ <= '0;
    end else begin
      if (idleStb && grantValid) begin
        if (grantOwner == OWN_CPU && statCpuQ != '1) statCpuQ <= statCpuQ + 32'd1;
        if (grantOwner == OWN_CON && statConQ != '1) statConQ <= statConQ + 32'd1;
      end
      if (conREQ && !(stateQ == ACK && ownerQ == OWN_CON) && statWaitQ != '1) begin
        statWaitQ <= statWaitQ + 32'd1;
      end
    end
  end

  assign statCPU  = statCpuQ;
  assign statCON  = statConQ;
  assign statWAIT = statWaitQ;
`else
  assign statCPU  = '0;
  assign statCON  = '0;
  assign statWAIT = '0;
`endif

endmodule
